audio_feed_i2c_ctrl: RTL
========================

Name: audio_feed_i2c_ctrl

Overview:
- Avalon-MM slave that performs complete I2C write transactions (device byte plus two data bytes) to configure the audio codec, e.g. WM8731 register writes.
- Replaces software bit-banging of the SCL/SDA PIOs with a hardware sequencer that has a programmable bit rate and ACK checking.
- Sits on the system interconnect beside the audio datapath and drives the codec's open-drain I2C pins.

Parameters:
- DIV_DEFAULT, 125, reset value of the quarter-bit divider (50 MHz / (4*125) = 100 kHz SCL).
- DIV_W, 16, width of the divider register and counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select: 0 DATA, 1 CTRL/STATUS, 2 DIV.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux.
- sda_in  in  1  synchronised level of the SDA pin.
- scl_oe  out  1  1 = pull SCL low; 0 = release.
- sda_oe  out  1  1 = pull SDA low; 0 = release.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Write qualifier: chipselect && !write_n.
- DATA (addr 0): bits [23:0] are written as {dev_byte, byte1, byte2}. Reads return {8'b0, DATA}. Writes are ignored while busy.
- CTRL (addr 1) writes:
  - bit0 = start; takes effect only if idle.
  - bit1 = 1 clears done and ack_err.
- STATUS (addr 1) reads: bit0 busy, bit1 ack_err, bit2 done; upper bits 0.
- DIV (addr 2): bits [DIV_W-1:0]; written values below 2 are clamped to 2. Reads return the current value. Writes are ignored while busy.
- Address 3 reads 0.
- Reset values:
  - scl_oe=0, sda_oe=0 (bus released).
  - busy=0, done=0, ack_err=0.
  - DATA=0, DIV=DIV_DEFAULT, state IDLE.
- Tick generation: the divider counts 0..DIV-1 only while busy. A tick pulses on wrap, so one phase = DIV clk cycles.
- FSM states: IDLE, START, BIT, ACK, STOP. Every non-IDLE state spends 4 phases (p0..p3).
  - IDLE: bus released. A start write sets busy on the next clk edge, clears done/ack_err, loads the shift register from DATA and enters START.
  - START:
    - p0: SDA, SCL released.
    - p1: SDA low.
    - p2: SCL low.
    - p3: hold.
    - Then BIT, with bit_cnt=7 and byte_cnt=0.
  - BIT:
    - p0: SCL low; SDA driven from the MSB of the current byte (sda_oe = !bit).
    - p1, p2: SCL released.
    - p3: SCL low.
    - At the end of p3, bit_cnt 0 goes to ACK; otherwise decrement.
  - ACK:
    - p0: SDA released, SCL low.
    - p1, p2: SCL released.
    - SDA is sampled on the last cycle of p2; sda_in=1 is a NACK, which sets ack_err and goes to STOP after p3.
    - On ACK after byte_cnt 2, go to STOP; otherwise byte_cnt++ and return to BIT.
  - STOP:
    - p0: SDA low, SCL low.
    - p1: SCL released.
    - p2: SDA released.
    - p3: hold.
    - Then IDLE with busy=0 and done=1 (done is also set on NACK).
- Length of a full ACKed transaction: (4 + 27*4 + 4) phases = 116*DIV cycles from the busy rise to busy fall.
- Bytes are transmitted MSB first.
- scl_oe and sda_oe are registered with no combinational path from the bus inputs.
- Simultaneous events:
  - A start write with bit1=1 clears the flags, then starts.
  - A DATA write in the same cycle as a start takes the new DATA value only if that write lands before the start; each write is one cycle, so it is naturally ordered.
- Reset mid-transaction: both lines are released immediately (asynchronous). No STOP is generated; software re-issues the transaction.

Decomposition:
- Shared package: state encoding constants (IDLE..STOP), register address constants (DATA=0, CTRL=1, DIV=2), and status bit indices.
- Natural sub-module: audio_feed_i2c_tick. It holds the divider counter, tick pulse and 2-bit phase counter, with enable and a DIV input.

Test Plan:
- Reset: assert reset_n=0 -> scl_oe=0, sda_oe=0, STATUS reads 0x0, DIV reads 125.
- Basic write: DIV=4, DATA=0x341800, CTRL=0x1, slave model ACKs all bytes.
  - Slave sees START, then bytes 0x34, 0x18, 0x00, then STOP.
  - busy is high for exactly 464 cycles.
  - STATUS then reads 0x4.
- NACK: slave NACKs the device byte.
  - STOP follows the first ACK slot; no further bytes are sent.
  - STATUS = 0x6.
  - CTRL write 0x2 -> STATUS = 0x0.
- Busy lockout: while busy, write DATA=0xFFFFFF, DIV=9 and CTRL=0x1.
  - The transaction in flight is unchanged; DATA and DIV reads return the old values.
  - No second transaction starts.
- DIV clamp and timing: write DIV=0 -> reads 2; each SCL high period = 4 cycles, each bit period = 8 cycles.
- Reset mid-byte: assert reset_n during BIT of byte1.
  - scl_oe and sda_oe are 0 in the same cycle.
  - After release, a new start completes normally with STATUS=0x4.

Source files
------------

// File: rtl/audio_feed_i2c_pkg.sv
// Shared definitions for the audio codec I2C write sequencer.
// State encoding, register map and status bit positions.
package audio_feed_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_ACK_ERR = 1;
    localparam int STAT_DONE    = 2;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

endpackage

// File: rtl/audio_feed_i2c_tick.sv
// Quarter-bit timebase: divider counter, phase tick and 2-bit phase.
// Held at zero while disabled so every transaction starts on a fresh phase.
module audio_feed_i2c_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic [1:0]       phase
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;

    // Count 0..div-1, pulse tick on wrap and advance the phase.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        tick    = 1'b0;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 2'd0;
        end else if (cnt_q == div - ONE) begin
            tick    = 1'b1;
            cnt_d   = '0;
            phase_d = phase_q + 2'd1;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Timebase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/audio_feed_i2c_ctrl.sv
// Avalon-MM I2C write sequencer for codec setup: device byte plus
// two data bytes, programmable bit rate, ACK checking, open-drain outputs.
module audio_feed_i2c_ctrl
    import audio_feed_i2c_pkg::*;
#(
    parameter int DIV_DEFAULT = 125,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sda_in,
    output logic        scl_oe,
    output logic        sda_oe
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    state_t           state_q, state_d;
    logic [23:0]      data_q, data_d;
    logic [23:0]      shift_q, shift_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             nack_q, nack_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             scl_oe_q, scl_oe_d;
    logic             sda_oe_q, sda_oe_d;

    logic             we;
    logic [DIV_W-1:0] wdiv;
    logic             tick;
    logic [1:0]       phase;
    logic             unused_wdata;

    assign we           = chipselect && !write_n;
    assign wdiv         = writedata[DIV_W-1:0];
    assign unused_wdata = ^writedata[31:24];

    audio_feed_i2c_tick #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (busy_q),
        .div   (div_q),
        .tick  (tick),
        .phase (phase)
    );

    // State register plus datapath and line drivers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            shift_q    <= '0;
            div_q      <= DIV_RST;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            nack_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            nack_q     <= nack_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    // Next state: register writes, start, bit/byte sequencing, ACK check.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        shift_d    = shift_q;
        div_d      = div_q;
        busy_d     = busy_q;
        done_d     = done_q;
        ack_err_d  = ack_err_q;
        nack_d     = nack_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;

        if (we && address == ADDR_DATA && !busy_q) begin
            data_d = writedata[23:0];
        end
        if (we && address == ADDR_DIV && !busy_q) begin
            div_d = (wdiv < DIV_MIN) ? DIV_MIN : wdiv;
        end
        if (we && address == ADDR_CTRL && writedata[CTRL_CLEAR]) begin
            done_d    = 1'b0;
            ack_err_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (we && address == ADDR_CTRL && writedata[CTRL_START]) begin
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    ack_err_d = 1'b0;
                    nack_d    = 1'b0;
                    shift_d   = data_q;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (tick && phase == 2'd3) begin
                    bit_cnt_d  = 3'd7;
                    byte_cnt_d = 2'd0;
                    state_d    = ST_BIT;
                end
            end
            ST_BIT: begin
                if (tick && phase == 2'd3) begin
                    shift_d = {shift_q[22:0], 1'b0};
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (tick && phase == 2'd2 && sda_in) begin
                    nack_d    = 1'b1;
                    ack_err_d = 1'b1;
                end
                if (tick && phase == 2'd3) begin
                    if (nack_q || byte_cnt_q == 2'd2) begin
                        state_d = ST_STOP;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        bit_cnt_d  = 3'd7;
                        state_d    = ST_BIT;
                    end
                end
            end
            ST_STOP: begin
                if (tick && phase == 2'd3) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    nack_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line levels for the current state and phase, registered above.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                sda_oe_d = (phase != 2'd0);
                scl_oe_d = phase[1];
            end
            ST_BIT: begin
                scl_oe_d = (phase == 2'd0) || (phase == 2'd3);
                sda_oe_d = !shift_q[23];
            end
            ST_ACK: begin
                scl_oe_d = (phase == 2'd0) || (phase == 2'd3);
            end
            ST_STOP: begin
                scl_oe_d = (phase == 2'd0);
                sda_oe_d = !phase[1];
            end
            default: begin
            end
        endcase
    end

    // Combinational register read mux.
    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_DATA: readdata[23:0] = data_q;
            ADDR_CTRL: begin
                readdata[STAT_BUSY]    = busy_q;
                readdata[STAT_ACK_ERR] = ack_err_q;
                readdata[STAT_DONE]    = done_q;
            end
            ADDR_DIV: readdata[DIV_W-1:0] = div_q;
            default: readdata = '0;
        endcase
    end

    assign scl_oe = scl_oe_q;
    assign sda_oe = sda_oe_q;

endmodule
